// File: rtl/contador16bits_checker_pkg.sv
// Shared constants for the 16-bit cascaded counter checker: counter mode codes
// and the checker FSM state encoding.
package contador16bits_checker_pkg;

  // Counter mode codes as driven on modo
  localparam logic [1:0] MODO_UP   = 2'b00;
  localparam logic [1:0] MODO_DN   = 2'b01;
  localparam logic [1:0] MODO_UP3  = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  // Checker FSM states; 2'b11 is unused and behaves as StSync
  typedef enum logic [1:0] {
    StSync  = 2'b00,
    StCheck = 2'b01,
    StHalt  = 2'b10
  } chk_state_e;

endpackage

// File: rtl/contador16bits_model.sv
// Flat single-clock reference step of the cascaded counter: given the current
// expected value and the sampled controls, returns {carry, next value}.
module contador16bits_model
  import contador16bits_checker_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] exp_q,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   nxt
);

  localparam logic [WIDTH:0]   One   = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   Three = (WIDTH+1)'(3);
  localparam logic [WIDTH-1:0] Dec   = WIDTH'(1);

  // Next expected value; the extra MSB is the final ripple carry
  always_comb begin
    nxt = {1'b0, exp_q};
    if (enb) begin
      unique case (modo)
        MODO_UP:   nxt = {1'b0, exp_q} + One;
        MODO_DN:   nxt = {(exp_q == '0), exp_q - Dec};
        MODO_UP3:  nxt = {1'b0, exp_q} + Three;
        MODO_LOAD: nxt = {1'b0, d};
        default:   nxt = {1'b0, exp_q};
      endcase
    end
  end

endmodule

// File: rtl/contador16bits_checker.sv
// Receiving-end monitor for the cascaded 16-bit counter. Tracks the counter
// with a flat model, compares Q and the final carry every cycle once synced
// by a load, and reports pulse / sticky / saturating counts.
module contador16bits_checker
  import contador16bits_checker_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned CHK_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               enb,
  input  logic [1:0]         modo,
  input  logic [WIDTH-1:0]   D,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH/4-1:0] RCO,
  output logic               synced,
  output logic               err_pulse,
  output logic               err_sticky,
  output logic [ERR_W-1:0]   err_count,
  output logic [CHK_W-1:0]   chk_count,
  output logic [1:0]         state
);

  chk_state_e       state_q;
  logic [WIDTH-1:0] exp_val_q;
  logic             exp_rco_q;
  logic             pend_q;
  logic             err_pulse_q;
  logic             err_sticky_q;
  logic [ERR_W-1:0] err_count_q;
  logic [CHK_W-1:0] chk_count_q;

  logic             mismatch;
  logic [WIDTH-1:0] model_base;
  logic [WIDTH:0]   model_nxt;

  // Lower nibble carries are only meaningful in chained-clock mode
  logic unused_rco;
  assign unused_rco = ^RCO;

  // Compare and choose the base for the next model step; on a resync the
  // observed Q becomes the base so a single jump is reported only once
  always_comb begin
    mismatch   = (Q != exp_val_q) || (RCO[WIDTH/4-1] != exp_rco_q);
    model_base = (mismatch && !STOP_ON_ERR) ? Q : exp_val_q;
  end

  contador16bits_model #(
    .WIDTH (WIDTH)
  ) u_model (
    .exp_q (model_base),
    .enb   (enb),
    .modo  (modo),
    .d     (D),
    .nxt   (model_nxt)
  );

  // Checker FSM, model registers and saturating counters
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q      <= StSync;
      exp_val_q    <= '0;
      exp_rco_q    <= 1'b0;
      pend_q       <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      chk_count_q  <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      case (state_q)
        StCheck: begin
          if (pend_q) begin
            if (chk_count_q != '1) chk_count_q <= chk_count_q + CHK_W'(1);
            if (mismatch) begin
              err_pulse_q  <= 1'b1;
              err_sticky_q <= 1'b1;
              if (err_count_q != '1) err_count_q <= err_count_q + ERR_W'(1);
              if (STOP_ON_ERR) state_q <= StHalt;
            end
            exp_val_q <= model_nxt[WIDTH-1:0];
            exp_rco_q <= model_nxt[WIDTH];
          end
        end
        StHalt: begin
          // Frozen until reset
        end
        default: begin
          if (enb && (modo == MODO_LOAD)) begin
            exp_val_q <= D;
            exp_rco_q <= 1'b0;
            pend_q    <= 1'b1;
            state_q   <= StCheck;
          end
        end
      endcase
    end
  end

  assign synced     = (state_q == StCheck);
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign chk_count  = chk_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_contador16bits_checker.sv
// Bench for contador16bits_checker: two instances (resync and halt-on-error,
// the latter with a narrow checked-cycle counter) driven by the same stimulus
// and compared each cycle against an arithmetic reference model.
module tb_contador16bits_checker;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        enb;
  logic [1:0]  modo;
  logic [15:0] D;
  logic [15:0] Q;
  logic [3:0]  RCO;

  logic        syn0, pul0, stk0, syn1, pul1, stk1;
  logic [7:0]  ec0, ec1;
  logic [15:0] cc0;
  logic [5:0]  cc1;
  logic [1:0]  st0, st1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state, index 0 = resync instance, 1 = halt instance
  int unsigned m_st[2], m_exp[2], m_rco[2], m_pulse[2], m_sticky[2], m_err[2], m_chk[2];
  int unsigned chk_max[2] = '{65535, 63};
  bit          stop[2]    = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  contador16bits_checker #(
    .WIDTH (16), .ERR_W (8), .CHK_W (16), .STOP_ON_ERR (1'b0)
  ) u_dut0 (
    .clk (clk), .reset_L (reset_L), .enb (enb), .modo (modo), .D (D), .Q (Q), .RCO (RCO),
    .synced (syn0), .err_pulse (pul0), .err_sticky (stk0), .err_count (ec0),
    .chk_count (cc0), .state (st0)
  );

  contador16bits_checker #(
    .WIDTH (16), .ERR_W (8), .CHK_W (6), .STOP_ON_ERR (1'b1)
  ) u_dut1 (
    .clk (clk), .reset_L (reset_L), .enb (enb), .modo (modo), .D (D), .Q (Q), .RCO (RCO),
    .synced (syn1), .err_pulse (pul1), .err_sticky (stk1), .err_count (ec1),
    .chk_count (cc1), .state (st1)
  );

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One counter step in plain arithmetic: returns {carry, value}
  function automatic bit [16:0] ref_step(input int unsigned v, input bit e, input int unsigned m,
                                         input int unsigned d);
    int unsigned s;
    if (!e) return {1'b0, 16'(v)};
    case (m)
      0: begin s = v + 1; return {s > 65535, 16'(s % 65536)}; end
      1: return {v == 0, 16'((v + 65535) % 65536)};
      2: begin s = v + 3; return {s > 65535, 16'(s % 65536)}; end
      default: return {1'b0, 16'(d)};
    endcase
  endfunction

  task automatic model_update(input bit rl, input bit e, input int unsigned m,
                              input int unsigned d, input int unsigned q, input bit r3);
    bit          bad;
    int unsigned base;
    bit [16:0]   nx;
    for (int s = 0; s < 2; s++) begin
      if (!rl) begin
        m_st[s] = 0; m_exp[s] = 0; m_rco[s] = 0; m_pulse[s] = 0;
        m_sticky[s] = 0; m_err[s] = 0; m_chk[s] = 0;
      end else begin
        m_pulse[s] = 0;
        if (m_st[s] == 0) begin
          if (e && m == 3) begin m_exp[s] = d; m_rco[s] = 0; m_st[s] = 1; end
        end else if (m_st[s] == 1) begin
          bad  = (q != m_exp[s]) || (int'(r3) != m_rco[s]);
          base = m_exp[s];
          if (m_chk[s] < chk_max[s]) m_chk[s]++;
          if (bad) begin
            m_pulse[s] = 1; m_sticky[s] = 1;
            if (m_err[s] < 255) m_err[s]++;
            if (stop[s]) m_st[s] = 2;
            base = q;
          end
          nx = ref_step(base, e, m, d);
          m_exp[s] = nx[15:0];
          m_rco[s] = nx[16];
        end
      end
    end
  endtask

  task automatic compare_all();
    check_val("state0", st0, m_st[0]);      check_val("state1", st1, m_st[1]);
    check_val("synced0", syn0, m_st[0] == 1); check_val("synced1", syn1, m_st[1] == 1);
    check_val("pulse0", pul0, m_pulse[0]);  check_val("pulse1", pul1, m_pulse[1]);
    check_val("sticky0", stk0, m_sticky[0]); check_val("sticky1", stk1, m_sticky[1]);
    check_val("errcnt0", ec0, m_err[0]);    check_val("errcnt1", ec1, m_err[1]);
    check_val("chkcnt0", cc0, m_chk[0]);    check_val("chkcnt1", cc1, m_chk[1]);
  endtask

  // Drive one cycle, step the model on the edge, sample 1 time unit later
  task automatic cyc(input bit rl, input bit e, input bit [1:0] m, input bit [15:0] d,
                     input bit [15:0] q, input bit r3);
    reset_L = rl; enb = e; modo = m; D = d; Q = q; RCO = {r3, 3'($urandom)};
    @(posedge clk);
    model_update(rl, e, m, d, q, r3);
    #1;
    compare_all();
  endtask

  initial begin
    bit [15:0] cnt;
    bit        crr;
    bit        rl, e, r3;
    bit [1:0]  m;
    bit [15:0] d, q;

    // Reset, then counting without a load must not sync
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 16'($urandom), 16'($urandom), 0);
    check_val("nosync_state", st0, 0);
    check_val("nosync_chk", cc0, 0);
    check_val("nosync_err", ec0, 0);

    // Sync on load, count up
    cyc(1, 1, 3, 16'h1234, 16'h0000, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 16'(16'h1234 + i), 0);
    check_val("up_chk", cc0, 4);
    check_val("up_synced", syn0, 1);
    check_val("up_err", ec0, 0);

    // Final carry on FFFF->0000, good then bad
    cyc(1, 1, 3, 16'hFFFF, 16'h1238, 0);
    cyc(1, 1, 0, 0, 16'hFFFF, 0);
    cyc(1, 1, 3, 16'hFFFF, 16'h0000, 1);
    check_val("carry_ok_err", ec0, 0);
    cyc(1, 1, 0, 0, 16'hFFFF, 0);
    cyc(1, 1, 3, 16'h0001, 16'h0000, 0);
    check_val("carry_bad_pulse", pul0, 1);
    check_val("carry_bad_err", ec0, 1);
    check_val("carry_bad_sticky", stk0, 1);
    check_val("carry_bad_halt", st1, 2);
    cyc(1, 1, 0, 0, 16'h0001, 0);
    check_val("after_load_pulse", pul0, 0);
    check_val("after_load_err", ec0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    check_val("rst_sticky0", stk0, 0);
    check_val("rst_state1", st1, 0);

    // Down with wrap, +3 with carry, enb=0 hold
    cyc(1, 1, 3, 16'h0001, 16'h0000, 0);
    cyc(1, 1, 1, 0, 16'h0001, 0);
    cyc(1, 1, 1, 0, 16'h0000, 0);
    cyc(1, 1, 3, 16'hFFFE, 16'hFFFF, 1);
    cyc(1, 1, 2, 0, 16'hFFFE, 0);
    cyc(1, 0, 2, 0, 16'h0001, 1);
    cyc(1, 0, 0, 0, 16'h0001, 0);
    check_val("dn_up3_err0", ec0, 0);
    check_val("dn_up3_err1", ec1, 0);

    // Injected jump: resync instance reports once, halt instance freezes
    cyc(1, 1, 3, 16'h0010, 16'h0001, 0);
    cyc(1, 1, 0, 0, 16'h0050, 0);
    cyc(1, 1, 0, 0, 16'h0051, 0);
    check_val("resync_err", ec0, 1);
    check_val("resync_pulse", pul0, 0);
    check_val("halt_state", st1, 2);
    check_val("halt_err", ec1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 16'h0999, 0);
    check_val("halt_nopulse", pul1, 0);
    check_val("halt_err_frozen", ec1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    check_val("rst_err0", ec0, 0);
    check_val("rst_chk0", cc0, 0);
    check_val("rst_err1", ec1, 0);

    // Error counter saturation: every compare is wrong
    cyc(1, 1, 3, 16'($urandom), 0, 0);
    for (int i = 0; i < 300; i++)
      cyc(1, 1'($urandom), 2'($urandom_range(0, 2)), 0, 16'(m_exp[0] ^ 32'h8000), 0);
    check_val("err_sat", ec0, 255);
    cyc(0, 0, 0, 0, 0, 0);

    // Random traffic from an ideal counter; first stretch is fault-free so the
    // narrow checked-cycle counter saturates
    cnt = 16'($urandom);
    crr = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      rl = (i < 200) ? 1'b1 : ($urandom_range(0, 299) != 0);
      e  = ($urandom_range(0, 3) != 0);
      m  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (i < 10) begin e = 1'b1; m = 2'b11; end
      d  = 16'($urandom);
      q  = cnt;
      r3 = crr;
      if (i >= 200 && $urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          q   = q ^ 16'(1 << $urandom_range(0, 15));
          cnt = q;
        end else begin
          r3 = ~r3;
        end
      end
      cyc(rl, e, m, d, q, r3);
      {crr, cnt} = ref_step(cnt, e, m, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
